// File: rtl/sound_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package    : sound_pkg                                           |
// | Description: Shared constants and request-FSM state encoding for |
// |              the sound-out sample buffer.                        |
// | Revision   : 1.0 - initial release                               |
// +------------------------------------------------------------------+
package sound_pkg;

  localparam int SAMPLE_W      = 32;
  localparam int DEF_DEPTH     = 16;
  localparam int DEF_LOW_WM    = 4;
  localparam int DEF_BURST_LEN = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } req_state_e;

endpackage : sound_pkg
`default_nettype wire

// File: rtl/sound_fifo_mem.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module     : sound_fifo_mem                                      |
// | Description: DEPTH x SAMPLE_W sample storage, registered write,  |
// |              combinational read at the read address.             |
// | Revision   : 1.0 - initial release                               |
// +------------------------------------------------------------------+
module sound_fifo_mem
  import sound_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                wr_en_i,
  input  logic [AW-1:0]       wr_addr_i,
  input  logic [SAMPLE_W-1:0] wr_data_i,
  input  logic [AW-1:0]       rd_addr_i,
  output logic [SAMPLE_W-1:0] rd_data_o
);

  logic [SAMPLE_W-1:0] mem_q [DEPTH];

  // Store the incoming word; contents need no reset since pointers gate validity
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule : sound_fifo_mem
`default_nettype wire

// File: rtl/sound_out_buffer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module     : sound_out_buffer                                    |
// | Description: Sample FIFO between the sound-out DMA word stream   |
// |              and the I2S sender, with watermark/burst refill     |
// |              request FSM, sticky overflow and underrun pulse.    |
// | Option     : define SOUND_OUT_UNDERRUN_STATS_EN to add the       |
// |              saturating underrun_count output.                   |
// | Revision   : 1.0 - initial release                               |
// +------------------------------------------------------------------+
module sound_out_buffer
  import sound_pkg::*;
#(
  parameter int DEPTH     = DEF_DEPTH,
  parameter int LOW_WM    = DEF_LOW_WM,
  parameter int BURST_LEN = DEF_BURST_LEN
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     in_valid,
  input  logic [SAMPLE_W-1:0]      in_data,
  output logic                     sound_req,
  output logic                     out_valid,
  output logic [SAMPLE_W-1:0]      out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     underrun
`ifdef SOUND_OUT_UNDERRUN_STATS_EN
  ,
  output logic [15:0]              underrun_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(BURST_LEN + 1);
  localparam logic [PW-1:0] LOW_WM_LVL = PW'(LOW_WM);
  localparam logic [CW-1:0] BURST_LAST = CW'(BURST_LEN - 1);

  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic                overflow_q, overflow_d;
  logic                primed_q, primed_d;
  req_state_e          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                sound_req_q;
  logic                full, empty, rd_en, wr_en;
  logic [SAMPLE_W-1:0] rd_data;

  // Full when pointers differ only in the wrap bit; empty when identical
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign out_valid = !empty && enable;
  assign rd_en     = out_valid && out_ready;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts
  assign wr_en     = in_valid && enable && (!full || rd_en);
  assign level     = wr_ptr_q - rd_ptr_q;
  // Head word is only presented while valid, so idle/reset shows zero
  assign out_data  = out_valid ? rd_data : '0;
  // Sender wants data but none is there, after streaming has started
  assign underrun  = enable && primed_q && out_ready && !out_valid;
  assign overflow  = overflow_q;
  assign sound_req = sound_req_q;

  sound_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_ptr_q[AW-1:0]),
    .wr_data_i (in_data),
    .rd_addr_i (rd_ptr_q[AW-1:0]),
    .rd_data_o (rd_data)
  );

  // Pointer, overflow and primed next-state; enable low flushes everything
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    primed_d   = primed_q;
    if (!enable) begin
      rd_ptr_d   = wr_ptr_q;
      overflow_d = 1'b0;
      primed_d   = 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (rd_en) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
        primed_d = 1'b1;
      end
      if (in_valid && full && !rd_en) begin
        overflow_d = 1'b1;
      end
    end
  end

  // Request FSM: request below watermark, count one burst, settle one cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (level <= LOW_WM_LVL) begin
            state_d = ST_REQ;
            cnt_d   = '0;
          end
        end
        ST_REQ: begin
          if (wr_en) begin
            if (cnt_q == BURST_LAST) begin
              state_d = ST_WAIT;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        ST_WAIT: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State registers; sound_req is registered from the next state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      primed_q    <= 1'b0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sound_req_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      primed_q    <= primed_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sound_req_q <= (state_d == ST_REQ);
    end
  end

`ifdef SOUND_OUT_UNDERRUN_STATS_EN
  logic [15:0] ucnt_q;

  // Saturating count of underrun pulses, cleared while disabled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ucnt_q <= '0;
    end else if (!enable) begin
      ucnt_q <= '0;
    end else if (underrun && (ucnt_q != 16'hFFFF)) begin
      ucnt_q <= ucnt_q + 16'd1;
    end
  end

  assign underrun_count = ucnt_q;
`endif

endmodule : sound_out_buffer
`default_nettype wire

// File: tb/tb_sound_out_buffer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module     : tb_sound_out_buffer                                 |
// | Description: Self-checking bench for sound_out_buffer: vector    |
// |              table plus scoreboard model sampled on negedge.     |
// | Option     : SOUND_OUT_UNDERRUN_STATS_EN also checks the count.  |
// | Revision   : 1.0 - initial release                               |
// +------------------------------------------------------------------+
module tb_sound_out_buffer;
  import sound_pkg::*;

  localparam int DEPTH     = 16;
  localparam int LOW_WM    = 4;
  localparam int BURST_LEN = 4;

  logic        clk = 1'b0;
  logic        reset_n, enable, in_valid, out_ready;
  logic [31:0] in_data;
  logic        sound_req, out_valid, overflow, underrun;
  logic [31:0] out_data;
  logic [4:0]  level;
`ifdef SOUND_OUT_UNDERRUN_STATS_EN
  logic [15:0] underrun_count;
`endif

  always #5 clk = ~clk;

  sound_out_buffer #(
    .DEPTH     (DEPTH),
    .LOW_WM    (LOW_WM),
    .BURST_LEN (BURST_LEN)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .sound_req (sound_req),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .level     (level),
    .overflow  (overflow),
    .underrun  (underrun)
`ifdef SOUND_OUT_UNDERRUN_STATS_EN
    ,
    .underrun_count (underrun_count)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_pulse  = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard / reference model, evaluated at negedge with stable inputs
  logic [31:0] q[$];
  req_state_e  m_state;
  int          m_cnt, m_ucnt, m_lvl;
  logic        m_ovf, m_primed, m_valid, m_pop, m_full, m_wr, m_und;

  always @(negedge clk) begin
    if (!reset_n) begin
      q.delete();
      m_ovf = 1'b0; m_primed = 1'b0; m_state = ST_IDLE; m_cnt = 0; m_ucnt = 0;
      chk1("rst_sound_req", sound_req, 1'b0);
      chk1("rst_out_valid", out_valid, 1'b0);
      chk32("rst_level", 32'(level), 32'd0);
    end else begin
      m_lvl   = q.size();
      m_valid = enable && (m_lvl != 0);
      m_pop   = m_valid && out_ready;
      m_full  = (m_lvl == DEPTH);
      m_wr    = in_valid && enable && (!m_full || m_pop);
      m_und   = enable && m_primed && out_ready && !m_valid;
      chk1("mon_out_valid", out_valid, m_valid);
      if (m_valid) chk32("mon_out_data", out_data, q[0]);
      chk32("mon_level", 32'(level), 32'(m_lvl));
      chk1("mon_overflow", overflow, m_ovf);
      chk1("mon_underrun", underrun, m_und);
      chk1("mon_sound_req", sound_req, m_state == ST_REQ);
`ifdef SOUND_OUT_UNDERRUN_STATS_EN
      chk32("mon_underrun_count", 32'(underrun_count), 32'(m_ucnt));
`endif
      if (underrun) n_pulse++;
      if (!enable) begin
        q.delete();
        m_ovf = 1'b0; m_primed = 1'b0; m_state = ST_IDLE; m_cnt = 0; m_ucnt = 0;
      end else begin
        if (m_pop) begin
          void'(q.pop_front());
          m_primed = 1'b1;
        end
        if (m_wr) q.push_back(in_data);
        if (in_valid && m_full && !m_pop) m_ovf = 1'b1;
        if (m_und && m_ucnt != 32'hFFFF) m_ucnt++;
        case (m_state)
          ST_IDLE: if (m_lvl <= LOW_WM) begin m_state = ST_REQ; m_cnt = 0; end
          ST_REQ: if (m_wr) begin
            m_cnt++;
            if (m_cnt == BURST_LEN) begin m_state = ST_WAIT; m_cnt = 0; end
          end
          default: m_state = ST_IDLE;
        endcase
      end
    end
  end

  typedef struct {
    logic        en;
    logic        iv;
    logic [31:0] d;
    logic        rdy;
    logic [4:0]  lvl;
    logic        req;
    logic        vld;
    logic [31:0] dat;
    logic        ovf;
  } vec_t;

  vec_t tv [8];
  int   p0;

  initial begin
    //           en    iv    data          rdy   lvl   req   vld   out_data      ovf
    tv[0] = '{1'b1, 1'b0, 32'h0000_0000, 1'b0, 5'd0, 1'b1, 1'b0, 32'h0000_0000, 1'b0};
    tv[1] = '{1'b1, 1'b1, 32'h0001_0002, 1'b0, 5'd1, 1'b1, 1'b1, 32'h0001_0002, 1'b0};
    tv[2] = '{1'b1, 1'b1, 32'h0003_0004, 1'b0, 5'd2, 1'b1, 1'b1, 32'h0001_0002, 1'b0};
    tv[3] = '{1'b1, 1'b1, 32'h0005_0006, 1'b0, 5'd3, 1'b1, 1'b1, 32'h0001_0002, 1'b0};
    tv[4] = '{1'b1, 1'b1, 32'h0007_0008, 1'b0, 5'd4, 1'b0, 1'b1, 32'h0001_0002, 1'b0};
    tv[5] = '{1'b1, 1'b0, 32'h0000_0000, 1'b0, 5'd4, 1'b0, 1'b1, 32'h0001_0002, 1'b0};
    tv[6] = '{1'b1, 1'b0, 32'h0000_0000, 1'b0, 5'd4, 1'b1, 1'b1, 32'h0001_0002, 1'b0};
    tv[7] = '{1'b1, 1'b1, 32'h0009_000A, 1'b0, 5'd5, 1'b1, 1'b1, 32'h0001_0002, 1'b0};

    reset_n = 1'b0; enable = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) cyc();
    chk1("reset_sound_req", sound_req, 1'b0);
    chk1("reset_out_valid", out_valid, 1'b0);
    chk32("reset_out_data", out_data, 32'h0);
    chk32("reset_level", 32'(level), 32'd0);
    chk1("reset_overflow", overflow, 1'b0);
    chk1("reset_underrun", underrun, 1'b0);
    reset_n = 1'b1;
    cyc();

    // Vector table: enable from empty, one burst of four, re-request
    for (int i = 0; i < 8; i++) begin
      enable = tv[i].en; in_valid = tv[i].iv; in_data = tv[i].d; out_ready = tv[i].rdy;
      cyc();
      chk32($sformatf("tv%0d_level", i), 32'(level), 32'(tv[i].lvl));
      chk1($sformatf("tv%0d_sound_req", i), sound_req, tv[i].req);
      chk1($sformatf("tv%0d_out_valid", i), out_valid, tv[i].vld);
      chk32($sformatf("tv%0d_out_data", i), out_data, tv[i].dat);
      chk1($sformatf("tv%0d_overflow", i), overflow, tv[i].ovf);
    end
    in_valid = 1'b0;

    // Fill to full, then one dropped word
    for (int i = 0; i < 11; i++) begin
      in_valid = 1'b1; in_data = 32'hA000_0000 + 32'(i);
      cyc();
    end
    chk32("fill_level", 32'(level), 32'd16);
    chk1("fill_overflow", overflow, 1'b0);
    in_data = 32'hBAD0_BAD0;
    cyc();
    chk32("drop_level", 32'(level), 32'd16);
    chk1("drop_overflow", overflow, 1'b1);

    // Simultaneous write and pop while full
    in_data = 32'h5151_5151; out_ready = 1'b1;
    cyc();
    in_valid = 1'b0; out_ready = 1'b0;
    chk32("full_rw_level", 32'(level), 32'd16);

    // Drain to the watermark, let the FSM start a burst, then two writes
    out_ready = 1'b1;
    repeat (12) cyc();
    out_ready = 1'b0;
    chk32("drain_level", 32'(level), 32'd4);
    repeat (3) cyc();
    chk1("wm_sound_req", sound_req, 1'b1);
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 32'hC0DE_0000 + 32'(i);
      cyc();
    end
    in_valid = 1'b0;
    chk32("midburst_level", 32'(level), 32'd6);
    chk1("midburst_overflow", overflow, 1'b1);
    chk1("midburst_sound_req", sound_req, 1'b1);

    // Enable low flushes on the next cycle
    enable = 1'b0;
    cyc();
    chk32("flush_level", 32'(level), 32'd0);
    chk1("flush_overflow", overflow, 1'b0);
    chk1("flush_sound_req", sound_req, 1'b0);
    chk1("flush_out_valid", out_valid, 1'b0);
    enable = 1'b1;

    // Not primed yet: empty with ready produces no underrun
    out_ready = 1'b1;
    p0 = n_pulse;
    repeat (3) cyc();
    chk32("unprimed_pulses", 32'(n_pulse - p0), 32'd0);
    out_ready = 1'b0;

    // Write latency, then prime with a pop and count three underruns
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
    cyc();
    in_valid = 1'b0;
    chk1("beef_out_valid", out_valid, 1'b1);
    chk32("beef_out_data", out_data, 32'hDEAD_BEEF);
    chk32("beef_level", 32'(level), 32'd1);
    out_ready = 1'b1;
    cyc();
    chk32("beef_pop_level", 32'(level), 32'd0);
    p0 = n_pulse;
    repeat (3) cyc();
    out_ready = 1'b0;
    chk32("primed_pulses", 32'(n_pulse - p0), 32'd3);
`ifdef SOUND_OUT_UNDERRUN_STATS_EN
    chk32("underrun_count", 32'(underrun_count), 32'd3);
`endif

    // Order preserved over a full FIFO of distinct words
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = 32'h1111_0000 + 32'(i) * 32'h0101;
      cyc();
    end
    in_valid = 1'b0;
    chk32("order_full_level", 32'(level), 32'd16);
    out_ready = 1'b1;
    repeat (16) cyc();
    out_ready = 1'b0;
    chk32("order_drained_level", 32'(level), 32'd0);

    // Asynchronous reset in the middle of a write cycle
    in_valid = 1'b1; in_data = 32'hCAFE_0001;
    cyc();
    chk32("pre_arst_level", 32'(level), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk32("arst_level", 32'(level), 32'd0);
    chk1("arst_sound_req", sound_req, 1'b0);
    chk1("arst_out_valid", out_valid, 1'b0);
    chk32("arst_out_data", out_data, 32'h0);
    chk1("arst_overflow", overflow, 1'b0);
    chk1("arst_underrun", underrun, 1'b0);
`ifdef SOUND_OUT_UNDERRUN_STATS_EN
    chk32("arst_underrun_count", 32'(underrun_count), 32'd0);
`endif
    in_valid = 1'b0;
    cyc();
    reset_n = 1'b1;
    repeat (2) cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_sound_out_buffer
`default_nettype wire
